// File: rtl/bk_arb_pkg.sv
// Shared constants, FSM state type and adder bus packing for the shared
// Brent-Kung adder arbiter.
package bk_arb_pkg;

   localparam int ADD_W    = 12;
   localparam int BK_IN_W  = 24;
   localparam int BK_OUT_W = 13;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } arb_state_t;

   // Adder input bus interleaves operand bits: a[i] at 2i, b[i] at 2i+1.
   function automatic logic [BK_IN_W-1:0] bk_interleave(input logic [ADD_W-1:0] a,
                                                        input logic [ADD_W-1:0] b);
      logic [BK_IN_W-1:0] v;
      v = '0;
      for (int i = 0; i < ADD_W; i++) begin
         v[2*i]   = a[i];
         v[2*i+1] = b[i];
      end
      return v;
   endfunction

endpackage

// File: rtl/bk_adder_arbiter_if.sv
// Request/response bundle between the client datapaths and the adder arbiter.
// Handshake: a transfer happens on a rising clk edge where valid & ready are both high;
// the source holds its valid and payload until that edge, ready may depend on valid.
interface bk_adder_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*12-1:0] req_a;
   logic [NREQ*12-1:0] req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [IDW-1:0]     rsp_id;
   logic [11:0]        rsp_sum;
   logic               rsp_cout;
   logic               busy;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );
endinterface

// File: rtl/BrentKung.sv
// 12-bit combinational Brent-Kung adder on an interleaved operand bus, no carry-in.
module BrentKung
   import bk_arb_pkg::*;
(
   input  logic [BK_IN_W-1:0]  INPUTS,
   output logic [BK_OUT_W-1:0] OUTS
);

   logic [ADD_W-1:0] hp;
   logic [ADD_W-1:0] gg;
   logic [ADD_W-1:0] pp;

   always_comb begin
      hp = '0;
      gg = '0;
      for (int i = 0; i < ADD_W; i++) begin
         hp[i] = INPUTS[2*i] ^ INPUTS[2*i+1];
         gg[i] = INPUTS[2*i] & INPUTS[2*i+1];
      end
      pp = hp;
      // Up-sweep builds group generate/propagate on power-of-two spans.
      for (int d = 1; d < ADD_W; d = d * 2) begin
         for (int i = 2*d - 1; i < ADD_W; i = i + 2*d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
      // Down-sweep fills the remaining prefixes from the span roots.
      for (int d = 8; d >= 1; d = d / 2) begin
         for (int i = 3*d - 1; i < ADD_W; i = i + 2*d) begin
            gg[i] = gg[i] | (pp[i] & gg[i-d]);
            pp[i] = pp[i] & pp[i-d];
         end
      end
   end

   assign OUTS = {gg[ADD_W-1], hp ^ {gg[ADD_W-2:0], 1'b0}};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after last_grant, wrapping modulo NREQ.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   input  logic            en,
   output logic [NREQ-1:0] grant_onehot,
   output logic [IDW-1:0]  grant_idx,
   output logic            any
);

   always_comb begin
      any          = 1'b0;
      grant_idx    = '0;
      grant_onehot = '0;
      // Two passes: indices above last_grant first, then the wrapped part.
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[i] && (i > int'(last_grant))) begin
            any       = 1'b1;
            grant_idx = i[IDW-1:0];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!any && req[i] && (i <= int'(last_grant))) begin
            any       = 1'b1;
            grant_idx = i[IDW-1:0];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         grant_onehot[i] = en && any && (grant_idx == i[IDW-1:0]);
      end
   end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Shares one Brent-Kung adder among NREQ requesters: round-robin accept,
// one operation in flight, result returned with the owner's id.
module bk_adder_arbiter
   import bk_arb_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   bk_adder_arbiter_if.slave   bus,
   output arb_state_t          dbg_state
);

   localparam int IDW = $clog2(NREQ);

   arb_state_t            state;
   logic [IDW-1:0]        last_grant;
   logic [ADD_W-1:0]      op_a;
   logic [ADD_W-1:0]      op_b;
   logic [IDW-1:0]        op_id;
   logic                  rsp_valid_q;
   logic [IDW-1:0]        rsp_id_q;
   logic [ADD_W-1:0]      rsp_sum_q;
   logic                  rsp_cout_q;
   logic                  busy_q;

   logic                  window;
   logic                  accept;
   logic                  any;
   logic [IDW-1:0]        grant_idx;
   logic [ADD_W-1:0]      sel_a;
   logic [ADD_W-1:0]      sel_b;
   logic [BK_OUT_W-1:0]   add_out;

   assign window = (state == IDLE) || ((state == HOLD) && bus.rsp_ready);
   assign accept = window && any;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req          (bus.req_valid),
      .last_grant   (last_grant),
      .en           (window),
      .grant_onehot (bus.req_ready),
      .grant_idx    (grant_idx),
      .any          (any)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant_idx == i[IDW-1:0]) begin
            sel_a = bus.req_a[12*i +: 12];
            sel_b = bus.req_b[12*i +: 12];
         end
      end
   end

   // The adder sees only registered operands, never the live request buses.
   BrentKung u_add (
      .INPUTS (bk_interleave(op_a, op_b)),
      .OUTS   (add_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         last_grant  <= IDW'(NREQ - 1);
         op_a        <= '0;
         op_b        <= '0;
         op_id       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (accept) begin
            op_a       <= sel_a;
            op_b       <= sel_b;
            op_id      <= grant_idx;
            last_grant <= grant_idx;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  state  <= EXEC;
                  busy_q <= 1'b1;
               end
            end
            EXEC: begin
               rsp_sum_q   <= add_out[ADD_W-1:0];
               rsp_cout_q  <= add_out[ADD_W];
               rsp_id_q    <= op_id;
               rsp_valid_q <= 1'b1;
               state       <= HOLD;
            end
            HOLD: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= accept ? EXEC : IDLE;
                  busy_q      <= accept;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = busy_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Self-checking bench for bk_adder_arbiter: directed scenarios plus a randomized
// run against a transaction-level round-robin/adder model with an expected queue.
module tb_bk_adder_arbiter;
   import bk_arb_pkg::*;

   localparam int NREQ = 4;

   logic       clk;
   logic       rst_n;
   arb_state_t dbg_state;

   bk_adder_arbiter_if #(.NREQ(NREQ)) bus ();

   bk_adder_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #900000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   logic [15:0] exp_q[$];
   int          grant_log[$];
   int          cyc_log[$];
   int          n_acc = 0;
   int          m_last = NREQ - 1;
   bit          m_inflight = 0;
   bit          m_shown = 0;

   function automatic logic [15:0] pk(input int id, input int cout, input int sum);
      return 16'((id << 13) | (cout << 12) | sum);
   endfunction

   function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
      int idx;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (last + k) % NREQ;
         if (v[idx]) return idx;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [NREQ-1:0] exp_ready;
      bit              win;
      int              g;
      int              ai;
      int              bi;
      int              s;
      if (!rst_n) begin
         exp_q.delete();
         m_last     = NREQ - 1;
         m_inflight = 0;
         m_shown    = 0;
      end else begin
         exp_ready = '0;
         g         = -1;
         win       = !m_inflight || (m_shown && bus.rsp_ready);
         if (win) g = rr_pick(bus.req_valid, m_last);
         if (g >= 0) exp_ready[g] = 1'b1;
         check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
         check("rsp_valid", 32'(bus.rsp_valid), 32'(m_shown));
         check("busy", 32'(bus.busy), 32'(m_inflight));
         if (m_shown && exp_q.size() > 0)
            check("rsp_data", 32'(pk(int'(bus.rsp_id), int'(bus.rsp_cout), int'(bus.rsp_sum))),
                  32'(exp_q[0]));
         if (m_inflight && !m_shown) begin
            m_shown = 1;
         end else begin
            if (m_shown && bus.rsp_ready) begin
               void'(exp_q.pop_front());
               m_inflight = 0;
               m_shown    = 0;
            end
            if (g >= 0) begin
               ai = int'(bus.req_a[12*g +: 12]);
               bi = int'(bus.req_b[12*g +: 12]);
               s  = ai + bi;
               exp_q.push_back(pk(g, (s >> 12) & 1, s & 12'hFFF));
               m_inflight = 1;
               m_last     = g;
               grant_log.push_back(g);
               cyc_log.push_back(cyc);
               n_acc++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input int id, input logic [11:0] a, input logic [11:0] b);
      int n;
      n             = 0;
      bus.req_valid = '0;
      bus.req_valid[id] = 1'b1;
      bus.req_a[12*id +: 12] = a;
      bus.req_b[12*id +: 12] = b;
      @(negedge clk);
      while (!bus.req_ready[id] && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready[id]) check("grant_timeout", 32'(bus.req_ready), 32'(1 << id));
      @(posedge clk);
      #1;
      bus.req_valid = '0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.rsp_valid) check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
   endtask

   task automatic drain();
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   // ---------------- stimulus ----------------
   logic [11:0] t2_a[3] = '{12'hFFF, 12'h800, 12'h000};
   logic [11:0] t2_b[3] = '{12'h001, 12'h800, 12'h000};
   logic [11:0] t2_s[3] = '{12'h000, 12'h000, 12'h000};
   logic        t2_c[3] = '{1'b1, 1'b1, 1'b0};

   initial begin
      int start_acc;
      int c0;
      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      do_reset();

      // Reset values
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_sum", 32'(bus.rsp_sum), 32'd0);
      check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));

      // 1: single op, exact latency
      bus.req_valid = 4'b0001;
      bus.req_a[11:0] = 12'h0FF;
      bus.req_b[11:0] = 12'h001;
      @(negedge clk);
      check("t1_ready_c0", 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("t1_valid_c1", 32'(bus.rsp_valid), 32'd0);
      check("t1_busy_c1", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("t1_valid_c2", 32'(bus.rsp_valid), 32'd1);
      check("t1_sum", 32'(bus.rsp_sum), 32'h100);
      check("t1_cout", 32'(bus.rsp_cout), 32'd0);
      check("t1_id", 32'(bus.rsp_id), 32'd0);

      // 2: carry corner cases
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         do_op(0, t2_a[i], t2_b[i]);
         wait_rsp();
         check("t2_sum", 32'(bus.rsp_sum), 32'(t2_s[i]));
         check("t2_cout", 32'(bus.rsp_cout), 32'(t2_c[i]));
      end
      drain();

      // 3: all requesters valid, rotation and 2-cycle spacing
      do_reset();
      grant_log.delete();
      cyc_log.delete();
      for (int i = 0; i < NREQ; i++) begin
         bus.req_a[12*i +: 12] = 12'($urandom_range(0, 4095));
         bus.req_b[12*i +: 12] = 12'($urandom_range(0, 4095));
      end
      bus.req_valid = '1;
      for (int n = 0; n < 40 && grant_log.size() < 5; n++) begin
         @(posedge clk);
         #1;
      end
      bus.req_valid = '0;
      check("t3_count", 32'(grant_log.size() >= 5), 32'd1);
      for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
         check("t3_order", 32'(grant_log[i]), 32'(i % NREQ));
         if (i > 0) check("t3_spacing", 32'(cyc_log[i] - cyc_log[i-1]), 32'd2);
      end
      drain();

      // 4: stall in HOLD, then back-to-back accept of id 2
      bus.rsp_ready = 1'b0;
      do_op(1, 12'h123, 12'h456);
      wait_rsp();
      @(posedge clk);
      #1;
      bus.req_valid = 4'b0100;
      bus.req_a[24 +: 12] = 12'h00A;
      bus.req_b[24 +: 12] = 12'h00B;
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("t4_hold_sum", 32'(bus.rsp_sum), 32'h579);
         check("t4_hold_id", 32'(bus.rsp_id), 32'd1);
         check("t4_hold_ready", 32'(bus.req_ready), 32'd0);
         check("t4_hold_busy", 32'(bus.busy), 32'd1);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_b2b_ready", 32'(bus.req_ready), 32'h4);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      @(negedge clk);
      check("t4_exec_valid", 32'(bus.rsp_valid), 32'd0);
      check("t4_exec_busy", 32'(bus.busy), 32'd1);
      wait_rsp();
      check("t4_b2b_id", 32'(bus.rsp_id), 32'd2);
      check("t4_b2b_sum", 32'(bus.rsp_sum), 32'h015);

      // 5: reset in the middle of EXEC drops the op
      @(posedge clk);
      #1;
      do_op(0, 12'h321, 12'h111);
      rst_n = 1'b0;
      #1;
      check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t5_busy", 32'(bus.busy), 32'd0);
      check("t5_sum", 32'(bus.rsp_sum), 32'd0);
      check("t5_id", 32'(bus.rsp_id), 32'd0);
      check("t5_state", 32'(dbg_state), 32'(IDLE));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      bus.req_valid = '1;
      @(negedge clk);
      check("t5_first_grant", 32'(bus.req_ready), 32'h1);
      @(posedge clk);
      #1;
      bus.req_valid = '0;
      drain();

      // 6: randomized traffic with valid/ready stalls
      start_acc = n_acc;
      c0        = cyc;
      while ((n_acc - start_acc) < 10000 && (cyc - c0) < 70000) begin
         bus.req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
         bus.rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            bus.req_a[12*i +: 12] = 12'($urandom_range(0, 4095));
            bus.req_b[12*i +: 12] = 12'($urandom_range(0, 4095));
         end
         @(posedge clk);
         #1;
      end
      check("rand_ops_done", 32'((n_acc - start_acc) >= 10000), 32'd1);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("drain_idle", 32'(bus.busy), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
